// File: rtl/led_pkg.sv
// Shared constants and types for the board LED driver.
package led_pkg;

  localparam int LED_NUM_LEDS = 10;
  localparam int LED_SEL_W    = 4;

  typedef enum logic {
    LED_ONEHOT = 1'b0,
    LED_BAR    = 1'b1
  } led_mode_t;

endpackage

// File: rtl/led_decoder.sv
// Combinational LED index decoder: one-hot or thermometer pattern plus range flag.
module led_decoder
  import led_pkg::*;
#(
  parameter int NUM_LEDS = LED_NUM_LEDS,
  parameter int SEL_W    = LED_SEL_W
) (
  input  logic [SEL_W-1:0]    i_led_number,
  input  logic                i_bar_mode,
  output logic [NUM_LEDS-1:0] o_pattern,
  output logic                o_in_range
);

  // Index is widened by one bit so NUM_LEDS == 2**SEL_W still compares correctly.
  logic [SEL_W:0] w_index;
  led_mode_t      w_mode;
  logic           w_in_range;

  assign w_index    = {1'b0, i_led_number};
  assign w_mode     = led_mode_t'(i_bar_mode);
  assign w_in_range = (w_index < (SEL_W+1)'(NUM_LEDS));
  assign o_in_range = w_in_range;

  // Build the lit pattern; nothing is lit for an out-of-range index.
  always_comb begin
    o_pattern = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (w_mode == LED_BAR) begin
        o_pattern[i] = (w_index >= (SEL_W+1)'(i));
      end else begin
        o_pattern[i] = (w_index == (SEL_W+1)'(i));
      end
    end
    if (!w_in_range) begin
      o_pattern = '0;
    end
  end

endmodule

// File: rtl/led_output.sv
// Registered driver for the board LEDs (LEDR) from a 4-bit LED index.
// Optional feature macro: LED_BLINK_EN -- out-of-range indices flash all LEDs
// at a BLINK_DIV-cycle half-period instead of leaving them dark.
module led_output
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = LED_NUM_LEDS,
  parameter int SEL_W     = LED_SEL_W,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEL_W-1:0]    led_number,
  input  logic                bar_mode,
  output logic [NUM_LEDS-1:0] LEDR
);

  // Elaboration-time parameter sanity.
  if ((2 ** SEL_W) < NUM_LEDS) begin : g_bad_sel_w
    $error("led_output: SEL_W too narrow for NUM_LEDS");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("led_output: BLINK_DIV must be at least 1");
  end

  logic [NUM_LEDS-1:0] w_pattern;
  logic                w_in_range;
  logic [NUM_LEDS-1:0] w_oor_fill;

  led_decoder #(
    .NUM_LEDS (NUM_LEDS),
    .SEL_W    (SEL_W)
  ) u_decoder (
    .i_led_number (led_number),
    .i_bar_mode   (bar_mode),
    .o_pattern    (w_pattern),
    .o_in_range   (w_in_range)
  );

`ifdef LED_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_phase;

  // Free-running blink timer; the phase flips each time the count wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == CNT_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CNT_W'(1);
    end
  end

  assign w_oor_fill = {NUM_LEDS{r_phase}};
`else
  assign w_oor_fill = '0;
`endif

  // Output register: pins see only flop outputs, one cycle after the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LEDR <= '0;
    end else if (w_in_range) begin
      LEDR <= w_pattern;
    end else begin
      LEDR <= w_oor_fill;
    end
  end

endmodule

// File: tb/tb_led_output.sv
// Self-checking bench for led_output (default build, or LED_BLINK_EN with BLINK_DIV=4).
module tb_led_output;

  localparam int NUM    = 10;
  localparam int SW     = 4;
  localparam int TB_DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [SW-1:0] led_number = '0;
  logic          bar_mode = 1'b0;
  logic [NUM-1:0] LEDR;

  int n_checks = 0;
  int n_errors = 0;

  led_output #(
    .NUM_LEDS  (NUM),
    .SEL_W     (SW),
    .BLINK_DIV (TB_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_number (led_number),
    .bar_mode   (bar_mode),
    .LEDR       (LEDR)
  );

  always #5 clk = ~clk;

  // Reference: what LEDR must show for index n, mode bar, on the k-th edge after reset.
  function automatic logic [NUM-1:0] model_leds(int n, bit bar, int k);
    if (n < NUM) begin
      if (bar) return NUM'((1 << (n + 1)) - 1);
      return NUM'(1 << n);
    end
`ifdef LED_BLINK_EN
    if ((((k - 1) / TB_DIV) % 2) == 1) return '1;
    return '0;
`else
    if (k < 0) return '1;
    return '0;
`endif
  endfunction

  logic [NUM-1:0] m_exp = '0;
  int             m_edges = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_exp   <= '0;
      m_edges <= 0;
    end else begin
      m_exp   <= model_leds(int'(led_number), bar_mode, m_edges + 1);
      m_edges <= m_edges + 1;
    end
  end

  task automatic chk(input string name, input logic [NUM-1:0] act, input logic [NUM-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model", LEDR, m_exp);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    int             n;
    bit             bar;
    logic [NUM-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{4, 1'b0, 10'b0000010000});
    vecs.push_back('{4, 1'b1, 10'b0000011111});
    vecs.push_back('{7, 1'b0, 10'b0010000000});
    vecs.push_back('{0, 1'b1, 10'b0000000001});
    vecs.push_back('{9, 1'b1, 10'b1111111111});
    vecs.push_back('{9, 1'b0, 10'b1000000000});

    // 1. reset behaviour
    #1 rst_n = 1'b0;
    led_number = 4'd5;
    bar_mode   = 1'b0;
    repeat (3) step();
    chk("reset_hold", LEDR, 10'b0000000000);
    rst_n = 1'b1;
    step();
    chk("reset_release", LEDR, 10'b0000100000);

    // 2. one-hot sweep
    bar_mode = 1'b0;
    for (int n = 0; n < NUM; n++) begin
      led_number = SW'(n);
      step();
      chk($sformatf("onehot_%0d", n), LEDR, NUM'(1 << n));
      n_checks++;
      if ($countones(LEDR) != 1) begin
        n_errors++;
        $display("FAIL onehot_count_%0d: got %0d bits expected 1", n, $countones(LEDR));
      end
    end
    chk("onehot_9_literal", LEDR, 10'b1000000000);

    // 3. bar sweep
    bar_mode = 1'b1;
    for (int n = 0; n < NUM; n++) begin
      led_number = SW'(n);
      step();
      chk($sformatf("bar_%0d", n), LEDR, NUM'((1 << (n + 1)) - 1));
    end
    led_number = 4'd3;
    step();
    chk("bar_3_literal", LEDR, 10'b0000001111);

    // Mode changes mid-stream
    foreach (vecs[i]) begin
      led_number = SW'(vecs[i].n);
      bar_mode   = vecs[i].bar;
      step();
      chk($sformatf("vec_%0d", i), LEDR, vecs[i].exp);
    end

`ifndef LED_BLINK_EN
    // 4. out of range stays dark in both modes
    for (int m = 0; m < 2; m++) begin
      bar_mode = m[0];
      for (int n = NUM; n < 16; n++) begin
        led_number = SW'(n);
        step();
        chk($sformatf("oor_%0d_m%0d", n, m), LEDR, 10'b0000000000);
      end
    end
`else
    // 5. blink, counted from a fresh reset
    rst_n = 1'b0;
    led_number = 4'd12;
    bar_mode   = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4)  chk("blink_e4",  LEDR, 10'b0000000000);
      if (k == 5)  chk("blink_e5",  LEDR, 10'b1111111111);
      if (k == 8)  chk("blink_e8",  LEDR, 10'b1111111111);
      if (k == 9)  chk("blink_e9",  LEDR, 10'b0000000000);
    end
    led_number = 4'd3;
    step();
    chk("blink_inrange", LEDR, 10'b0000001000);
`endif

    // 6. async reset mid-run
    led_number = 4'd9;
    bar_mode   = 1'b0;
    step();
    chk("pre_async", LEDR, 10'b1000000000);
    rst_n = 1'b0;
    #1;
    chk("async_reset", LEDR, 10'b0000000000);
    repeat (2) step();
    rst_n = 1'b1;
    led_number = 4'd2;
    step();
    chk("post_async", LEDR, 10'b0000000100);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
